systolic_array_nxn: RTL and testbench
=====================================

SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 SHALL have parameter N, default 4: array dimension, NxN processing elements (PEs); legal values 2..8.
REQ-002 SHALL have parameter DW, default 8: operand and result data width.
REQ-003 SHALL have parameter ACC_W, default 24: PE accumulator width; ACC_W < 2*DW+clog2(N) SHALL be an elaboration error.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, ports as follows.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 we  input  1  write strobe for the load port.
REQ-008 sel  input  2  write target: 00 weight memory W, 01 feature memory A, 10 threshold register, 11 ignored.
REQ-009 addr  input  2*clog2(N)  load address = row*N+col.
REQ-010 data_in  input  DW  load data.
REQ-011 start  input  1  begin computation C = A x W.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse on completion.
REQ-014 rd_addr  input  2*clog2(N)  result read address = row*N+col.
REQ-015 rd_data  output  DW  registered result read, 1-cycle latency.

Function
REQ-016 Writes SHALL take effect only when we=1 and busy=0; writes while busy SHALL be ignored; addr >= N*N SHALL be ignored.
REQ-017 FSM SHALL have states IDLE, COMPUTE, WRITEBACK, DONE; start is sampled only in IDLE; start while busy SHALL be ignored.
REQ-018 On accepting start at edge 0, the FSM SHALL clear all PE accumulators, enter COMPUTE for cycles 1..3N-2, then enter WRITEBACK for cycles 3N-1..4N-2, then DONE at cycle 4N-1 (done=1, busy=0), then return to IDLE.
REQ-019 Dataflow SHALL be output-stationary: row r of A enters PE row r from the left, skewed by r cycles; column c of W enters PE column c from the top, skewed by c cycles; operands SHALL advance one PE per cycle and zeros SHALL be injected outside the valid window.
REQ-020 PE(r,c) SHALL accumulate the sum over k of A[r][k]*W[k][c], unsigned, full product width, in ACC_W bits.
REQ-021 Quantisation: accumulator > 2^DW-1 SHALL saturate to all-ones; otherwise it SHALL take the low DW bits.
REQ-022 WRITEBACK SHALL write one result row per cycle, row 0 first, into result memory R.
REQ-023 rd_data SHALL equal R[rd_addr] one cycle after rd_addr is presented, in any state; reads during WRITEBACK SHALL return pre- or post-write contents per row, consistently.
REQ-024 A and W SHALL remain unchanged by computation; back-to-back starts SHALL reproduce identical results.

Reset
REQ-025 When rst_n=0: FSM to IDLE, busy=0, done=0, rd_data=0, A, W and R all zero, threshold=0, accumulators zero.
REQ-026 Reset asserted mid-operation SHALL abort immediately; no partial results SHALL be retained.

Configuration
REQ-027 Macro SA_RELU_EN defined: sel=10 writes the DW-bit threshold register, and quantised results below threshold SHALL be written as 0.
REQ-028 Macro SA_RELU_EN undefined: no threshold register, sel=10 writes ignored, quantised results stored unmodified.

Verification
REQ-029 N=4, W=identity, A[r][c]=4r+c+1, start -> done pulse exactly 15 cycles after the start edge; R equals A.
REQ-030 N=4, all A=W=0xFF -> accumulator 260100 in every PE; every R entry reads 0xFF.
REQ-031 SA_RELU_EN defined, threshold 0x10, case REQ-029 -> R entries 1..15 read 0, entry 16 reads 0x10; macro undefined -> R equals A.
REQ-032 we=1 writing A and start=1 on cycles 3 and 6 of a run -> A unchanged, exactly one done pulse, results as expected.
REQ-033 rst_n low at cycle 5 of COMPUTE -> busy=0 next cycle, every rd_addr returns 0; a fresh load and start then completes correctly.
REQ-034 N=2, A=[[1,2],[3,4]], W=[[5,6],[7,8]] -> R=[[19,22],[43,50]], done at cycle 7.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// ---------------------------------------------------------------------------
// systolic_array_nxn
//
// Output-stationary NxN systolic matrix multiplier, C = A x W, all unsigned.
// Operands are loaded through a simple write port into flop-based A/W
// memories. A start runs the array, and the quantised results are written
// row by row into a result memory that has a registered read port.
//
// Optional feature macro: SA_RELU_EN
//   defined   : sel=10 writes a DW-bit threshold; results below it store as 0
//   undefined : no threshold register, sel=10 writes are dropped
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   we       in   load write strobe (ignored while busy)
//   sel      in   write target: 00 W, 01 A, 10 threshold, 11 none
//   addr     in   load address, row*N+col (>= N*N ignored)
//   data_in  in   load data
//   start    in   begin computation (sampled only when idle)
//   busy     out  computation / writeback in progress
//   done     out  one-cycle completion pulse
//   rd_addr  in   result read address, row*N+col
//   rd_data  out  registered result, one cycle after rd_addr
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; loads accepted
// S_COMPUTE | operands stream through the array, 3N-1 cycles
// S_WRITEBK | one result row per cycle into R, row 0 first
// S_DONE    | done pulse for one cycle, then back to idle
// ---------------------------------------------------------------------------
module systolic_array_nxn #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [1:0]                sel,
    input  logic [2*$clog2(N)-1:0]    addr,
    input  logic [DW-1:0]             data_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [2*$clog2(N)-1:0]    rd_addr,
    output logic [DW-1:0]             rd_data
);

    localparam int AW = 2 * $clog2(N);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] LAST_C  = CW'(3 * N - 2);
    localparam logic [CW-1:0] LAST_WB = CW'(N - 1);
    localparam logic [AW:0]   NN_A    = (AW + 1)'(NN);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("systolic_array_nxn: N must be in 2..8");
    end
    if (ACC_W < 2 * DW + $clog2(N)) begin : g_bad_acc
        $error("systolic_array_nxn: ACC_W too narrow for 2*DW+clog2(N)");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_WRITEBK = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic            clr;

    logic [DW-1:0]    a_mem_q [NN];
    logic [DW-1:0]    w_mem_q [NN];
    logic [DW-1:0]    r_mem_q [NN];
    logic [DW-1:0]    rd_q;

    logic [DW-1:0]    a_pipe_q [N][N];
    logic [DW-1:0]    w_pipe_q [N][N];
    logic [ACC_W-1:0] acc_q    [N][N];

    logic [DW-1:0]    a_edge [N];
    logic [DW-1:0]    w_edge [N];
    logic [DW-1:0]    a_in   [N][N];
    logic [DW-1:0]    w_in   [N][N];
    logic [DW-1:0]    res    [N][N];

    logic [CW-1:0]    step;
    logic [CW-1:0]    wb_row;
    logic             wr_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = S_COMPUTE;
                    tmr_d   = LAST_C;
                end
            end
            S_COMPUTE: begin
                if (tmr_q == '0) begin
                    state_d = S_WRITEBK;
                    tmr_d   = LAST_WB;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_WRITEBK: begin
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_COMPUTE) || (state_q == S_WRITEBK);
    assign done   = (state_q == S_DONE);
    // The phase timer counts down; the up-going step/row index is derived.
    assign step   = LAST_C - tmr_q;
    assign wb_row = LAST_WB - tmr_q;
    assign wr_ok  = we && !busy && ({1'b0, addr} < NN_A);

    // ------------------------------------------------------------------
    // Load port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem_q <= '{default: '0};
            w_mem_q <= '{default: '0};
        end else if (wr_ok) begin
            case (sel)
                2'b00:   w_mem_q[IW'(addr)] <= data_in;
                2'b01:   a_mem_q[IW'(addr)] <= data_in;
                default: ;
            endcase
        end
    end

`ifdef SA_RELU_EN
    logic [DW-1:0] thr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '0;
        end else if (wr_ok && sel == 2'b10) begin
            thr_q <= data_in;
        end
    end
`else
    // No threshold register; sel=10 falls into the ignored case above.
`endif

    // ------------------------------------------------------------------
    // Skewed edge injection: row r of A lags by r cycles, column c of W
    // by c cycles; outside the window the edges carry zero.
    // ------------------------------------------------------------------
    always_comb begin
        int k;
        k = 0;
        for (int r = 0; r < N; r++) begin
            a_edge[r] = '0;
            w_edge[r] = '0;
            if (state_q == S_COMPUTE) begin
                k = int'(step) - r;
                if (k >= 0 && k < N) begin
                    a_edge[r] = a_mem_q[IW'(r * N + k)];
                    w_edge[r] = w_mem_q[IW'(k * N + r)];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_in[r][0] = a_edge[r];
            w_in[0][r] = w_edge[r];
            for (int c = 1; c < N; c++) begin
                a_in[r][c] = a_pipe_q[r][c-1];
                w_in[c][r] = w_pipe_q[c-1][r];
            end
        end
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pipe_q <= '{default: '{default: '0}};
            w_pipe_q <= '{default: '{default: '0}};
            acc_q    <= '{default: '{default: '0}};
        end else if (clr) begin
            a_pipe_q <= '{default: '{default: '0}};
            w_pipe_q <= '{default: '{default: '0}};
            acc_q    <= '{default: '{default: '0}};
        end else if (state_q == S_COMPUTE) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_pipe_q[r][c] <= a_in[r][c];
                    w_pipe_q[r][c] <= w_in[r][c];
                    acc_q[r][c]    <= acc_q[r][c] +
                        ACC_W'({{DW{1'b0}}, a_in[r][c]} * {{DW{1'b0}}, w_in[r][c]});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quantisation (saturate on overflow of DW bits) and optional ReLU
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                res[r][c] = (|acc_q[r][c][ACC_W-1:DW]) ? '1 : acc_q[r][c][DW-1:0];
`ifdef SA_RELU_EN
                if (res[r][c] < thr_q) begin
                    res[r][c] = '0;
                end
`else
                // Quantised value stored unmodified.
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Result memory and registered read port. A read in the same cycle as
    // a row write returns the pre-write contents of that row.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_q <= '{default: '0};
        end else if (state_q == S_WRITEBK) begin
            for (int r = 0; r < N; r++) begin
                if (CW'(r) == wb_row) begin
                    for (int c = 0; c < N; c++) begin
                        r_mem_q[IW'(r * N + c)] <= res[r][c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if ({1'b0, rd_addr} < NN_A) begin
            rd_q <= r_mem_q[IW'(rd_addr)];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_nxn
//
// Directed bench for systolic_array_nxn: one N=4 instance and one N=2
// instance share clock and reset. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_systolic_array_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       we4, start4, busy4, done4;
    logic [1:0] sel4;
    logic [3:0] addr4, rda4;
    logic [7:0] din4, rdd4;

    logic       we2, start2, busy2, done2;
    logic [1:0] sel2;
    logic [1:0] addr2, rda2;
    logic [7:0] din2, rdd2;

    int vecs    = 0;
    int miscmp  = 0;

    systolic_array_nxn #(.N(4), .DW(8), .ACC_W(24)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .we(we4), .sel(sel4), .addr(addr4),
        .data_in(din4), .start(start4), .busy(busy4), .done(done4),
        .rd_addr(rda4), .rd_data(rdd4)
    );

    systolic_array_nxn #(.N(2), .DW(8), .ACC_W(24)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we2), .sel(sel2), .addr(addr2),
        .data_in(din2), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rda2), .rd_data(rdd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr4(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d);
        we4 = 1'b1; sel4 = s; addr4 = a; din4 = d;
        tick();
        we4 = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] s, input logic [1:0] a, input logic [7:0] d);
        we2 = 1'b1; sel2 = s; addr2 = a; din2 = d;
        tick();
        we2 = 1'b0;
    endtask

    // W = identity (off-diagonal assumed zero), A[r][c] = 4r+c+1
    task automatic load4_ident();
        for (int i = 0; i < 16; i++) wr4(2'b01, 4'(i), 8'(i + 1));
        for (int k = 0; k < 4; k++) wr4(2'b00, 4'(k * 5), 8'd1);
    endtask

    task automatic run4(input string tag);
        int lat;
        lat = -1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy4), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done4) begin
                lat = i;
                break;
            end
        end
        chk({tag, " done_latency"}, 32'(lat), 32'd15);
        chk({tag, " busy_at_done"}, 32'(busy4), 32'd0);
        tick();
    endtask

    task automatic rd4(input string tag, input int i, input logic [7:0] exp);
        rda4 = 4'(i);
        tick();
        chk($sformatf("%s R[%0d]", tag, i), 32'(rdd4), 32'(exp));
    endtask

    task automatic chk_r_eq_a(input string tag);
        for (int i = 0; i < 16; i++) rd4(tag, i, 8'(i + 1));
    endtask

    initial begin
        int ndone;
        int lat;
        logic [7:0] exp2 [4];

        rst_n  = 1'b0;
        we4 = 0; sel4 = 0; addr4 = 0; din4 = 0; start4 = 0; rda4 = 0;
        we2 = 0; sel2 = 0; addr2 = 0; din2 = 0; start2 = 0; rda2 = 0;
        tick();
        tick();
        chk("reset busy4",  32'(busy4), 32'd0);
        chk("reset done4",  32'(done4), 32'd0);
        chk("reset rdd4",   32'(rdd4),  32'd0);
        chk("reset busy2",  32'(busy2), 32'd0);
        chk("reset rdd2",   32'(rdd2),  32'd0);
        rst_n = 1'b1;
        tick();
        rd4("reset_mem", 5, 8'd0);

        // Identity weights: result equals A, done 15 cycles after start edge
        load4_ident();
        run4("ident");
        chk_r_eq_a("ident");

        // Threshold: only value 16 survives when the ReLU option is built in
        wr4(2'b10, 4'd0, 8'h10);
        run4("relu");
`ifdef SA_RELU_EN
        for (int i = 0; i < 16; i++) rd4("relu", i, (i + 1 >= 16) ? 8'(i + 1) : 8'd0);
`else
        chk_r_eq_a("relu");
`endif
        wr4(2'b10, 4'd0, 8'h00);

        // Writes and restarts while busy are ignored; one done pulse only
        ndone = 0;
        lat   = -1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 6) begin
                we4 = 1'b1; sel4 = 2'b01; addr4 = 4'd0; din4 = 8'hAA; start4 = 1'b1;
            end else begin
                we4 = 1'b0; start4 = 1'b0;
            end
            tick();
            if (done4) begin
                ndone++;
                lat = i;
            end
        end
        we4 = 1'b0; start4 = 1'b0;
        chk("busy_wr done_count", 32'(ndone), 32'd1);
        chk("busy_wr done_latency", 32'(lat), 32'd15);
        chk_r_eq_a("busy_wr");

        // Saturation: 4*255*255 = 260100 clips to 0xFF everywhere
        for (int i = 0; i < 16; i++) begin
            wr4(2'b00, 4'(i), 8'hFF);
            wr4(2'b01, 4'(i), 8'hFF);
        end
        run4("sat");
        for (int i = 0; i < 16; i++) rd4("sat", i, 8'hFF);

        // Reset during COMPUTE aborts and clears everything
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (4) tick();
        chk("abort busy_before_rst", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        chk("abort rdd",  32'(rdd4),  32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) rd4("abort", i, 8'd0);
        load4_ident();
        run4("reload");
        chk_r_eq_a("reload");

        // N=2: [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]]
        wr2(2'b01, 2'd0, 8'd1);
        wr2(2'b01, 2'd1, 8'd2);
        wr2(2'b01, 2'd2, 8'd3);
        wr2(2'b01, 2'd3, 8'd4);
        wr2(2'b00, 2'd0, 8'd5);
        wr2(2'b00, 2'd1, 8'd6);
        wr2(2'b00, 2'd2, 8'd7);
        wr2(2'b00, 2'd3, 8'd8);
        wr2(2'b11, 2'd0, 8'h77);
        lat = -1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("n2 busy_after_start", 32'(busy2), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done2) begin
                lat = i;
                break;
            end
        end
        chk("n2 done_latency", 32'(lat), 32'd7);
        tick();
        exp2[0] = 8'd19; exp2[1] = 8'd22; exp2[2] = 8'd43; exp2[3] = 8'd50;
        for (int i = 0; i < 4; i++) begin
            rda2 = 2'(i);
            tick();
            chk($sformatf("n2 R[%0d]", i), 32'(rdd2), 32'(exp2[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
